// File: rtl/muxn_pkg.sv
// rtl/muxn_pkg.sv - sizing helpers shared by the pipelined N:1 mux and its stages
package muxn_pkg;

    // Tree depth for n leaves. Never returns 0, so a 2:1 mux still gets one stage.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Leaf count after zero-padding n words up to the next power of two.
    function automatic int padded_count(input int n);
        return 1 << clog2_min1(n);
    endfunction

endpackage

// File: rtl/muxn_pipe_stage.sv
// rtl/muxn_pipe_stage.sv - one registered level of the pipelined mux tree
//
// Ports:
//   clk, rst      clock; asynchronous active-high clear of every register
//   advance       load enable shared by all levels (low = hold)
//   d_in          M words from the previous level (word j at d_in[j*W +: W])
//   sel_in        unconsumed select bits; bit 0 steers this level
//   err_in        out-of-range flag travelling with the item
//   valid_in      item valid from the previous level
//   echo_in       full original select, registered only when ECHO=1
//   d_q           M/2 registered words
//   sel_q         sel_in[SW-1:1] registered (tied 0 when nothing remains)
//   err_q         registered err_in
//   valid_q       registered valid_in
//   echo_q        registered echo_in (tied 0 when ECHO=0)
module muxn_pipe_stage
    import muxn_pkg::*;
#(
    parameter int M       = 2,
    parameter int W       = 32,
    parameter int SW      = 1,
    parameter int EW      = 1,
    parameter bit ECHO    = 1'b0,
    localparam int SOW    = (SW > 1) ? SW - 1 : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic [M*W-1:0]       d_in,
    input  logic [SW-1:0]        sel_in,
    input  logic                 err_in,
    input  logic                 valid_in,
    input  logic [EW-1:0]        echo_in,
    output logic [(M/2)*W-1:0]   d_q,
    output logic [SOW-1:0]       sel_q,
    output logic                 err_q,
    output logic                 valid_q,
    output logic [EW-1:0]        echo_q
);

    logic [(M/2)*W-1:0] d_pick;

    // Pair (2j, 2j+1); the odd entry wins when this level's select bit is set.
    always_comb begin
        d_pick = '0;
        for (int j = 0; j < M / 2; j++) begin
            d_pick[j*W +: W] = sel_in[0] ? d_in[(2*j+1)*W +: W] : d_in[(2*j)*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (advance) begin
            d_q     <= d_pick;
            err_q   <= err_in;
            valid_q <= valid_in;
        end
    end

    generate
        if (SW > 1) begin : g_sel
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sel_q <= '0;
                end else if (advance) begin
                    sel_q <= sel_in[SW-1:1];
                end
            end
        end else begin : g_nosel
            // Root level: every select bit has been consumed.
            assign sel_q = '0;
        end

        if (ECHO) begin : g_echo
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    echo_q <= '0;
                end else if (advance) begin
                    echo_q <= echo_in;
                end
            end
        end else begin : g_noecho
            logic unused_echo;
            assign unused_echo = ^echo_in;
            assign echo_q      = '0;
        end
    endgenerate

endmodule

// File: rtl/muxn_pipe.sv
// rtl/muxn_pipe.sv - pipelined N:1 word multiplexer with valid/ready backpressure
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   inputs       N packed words, word i at inputs[i*W +: W]
//   sel          index of the word to forward (L bits)
//   in_valid     inputs/sel valid this cycle
//   in_ready     pipeline accepts a transfer this cycle
//   out          selected word, 0 whenever out_valid=0
//   out_valid    out holds a result
//   out_ready    consumer accepts out this cycle
//   sel_err      with out_valid: the item's sel was >= N (out is then 0)
//   sel_out      original sel of the output item, 0 when idle
//                (present only with MUXN_PIPE_SEL_ECHO_EN defined)
//
// Optional feature macro: MUXN_PIPE_SEL_ECHO_EN
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32,
    localparam int L = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] inputs,
    input  logic [L-1:0]   sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sel_err
`ifdef MUXN_PIPE_SEL_ECHO_EN
    ,
    output logic [L-1:0]   sel_out
`endif
);

    localparam int PAD       = padded_count(N);
    // Level k keeps L-k select bits; the extra bit is the root stage's dummy slot.
    localparam int SEL_BITS  = (L * (L + 1)) / 2 + 1;
    localparam logic [31:0] N_U = N;
`ifdef MUXN_PIPE_SEL_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    // All tree levels packed back to back: level k holds PAD>>k words
    // starting at word offset 2*PAD - 2*(PAD>>k).
    wire  [(2*PAD-1)*W-1:0] tree_d;
    wire  [SEL_BITS-1:0]    tree_s;
    wire  [L:0]             tree_v;
    wire  [L:0]             tree_e;
    wire  [L-1:0]           tree_echo [0:L];
    logic [PAD*W-1:0]       leaf_d;
    logic                   advance;

    // The whole pipeline moves together; a stalled output freezes every level.
    assign advance  = !tree_v[L] || out_ready;
    assign in_ready = advance;

    // Zero padding doubles as the result for out-of-range selects.
    always_comb begin
        leaf_d          = '0;
        leaf_d[N*W-1:0] = inputs;
    end

    assign tree_d[PAD*W-1:0] = leaf_d;
    assign tree_s[L-1:0]     = sel;
    assign tree_v[0]         = in_valid;
    assign tree_e[0]         = ({{(32-L){1'b0}}, sel} >= N_U);
`ifdef MUXN_PIPE_SEL_ECHO_EN
    assign tree_echo[0]      = sel;
`else
    assign tree_echo[0]      = '0;
`endif

    generate
        for (genvar k = 1; k <= L; k++) begin : g_stage
            localparam int M   = PAD >> (k - 1);
            localparam int SW  = L - k + 1;
            localparam int SOW = (SW > 1) ? SW - 1 : 1;
            localparam int DI  = 2 * PAD - 2 * (PAD >> (k - 1));
            localparam int DO  = 2 * PAD - 2 * (PAD >> k);
            localparam int SI  = (k - 1) * L - ((k - 1) * (k - 2)) / 2;
            localparam int SO  = k * L - (k * (k - 1)) / 2;

            muxn_pipe_stage #(
                .M    (M),
                .W    (W),
                .SW   (SW),
                .EW   (L),
                .ECHO (ECHO)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .advance  (advance),
                .d_in     (tree_d[DI*W +: M*W]),
                .sel_in   (tree_s[SI +: SW]),
                .err_in   (tree_e[k-1]),
                .valid_in (tree_v[k-1]),
                .echo_in  (tree_echo[k-1]),
                .d_q      (tree_d[DO*W +: (M/2)*W]),
                .sel_q    (tree_s[SO +: SOW]),
                .err_q    (tree_e[k]),
                .valid_q  (tree_v[k]),
                .echo_q   (tree_echo[k])
            );
        end
    endgenerate

    assign out_valid = tree_v[L];
    assign out       = tree_v[L] ? tree_d[(2*PAD-2)*W +: W] : '0;
    assign sel_err   = tree_v[L] & tree_e[L];

`ifdef MUXN_PIPE_SEL_ECHO_EN
    assign sel_out   = tree_v[L] ? tree_echo[L] : '0;
`else
    logic unused_echo;
    assign unused_echo = ^tree_echo[L];
`endif

    logic unused_tail;
    assign unused_tail = tree_s[SEL_BITS-1];

endmodule

// File: tb/tb_muxn_pipe.sv
// tb/tb_muxn_pipe.sv - self-checking bench for muxn_pipe (N=8, 5, 4, 16)
module tb_muxn_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] cyc;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] words  [4][16];
    logic [3:0]  sel_d  [4];
    logic        inv_d  [4];
    logic        ordy_d [4];
    logic        ov_d   [4];
    logic        ir_d   [4];
    logic        se_d   [4];
    logic [31:0] out_d  [4];
    int          n_d    [4];
    int          lat_d  [4];
    bit          chk_lat[4];

    logic [8*32-1:0]  in0;
    logic [5*32-1:0]  in1;
    logic [4*32-1:0]  in2;
    logic [16*32-1:0] in3;

    always_comb begin
        for (int i = 0; i < 8; i++)  in0[i*32 +: 32] = words[0][i];
        for (int i = 0; i < 5; i++)  in1[i*32 +: 32] = words[1][i];
        for (int i = 0; i < 4; i++)  in2[i*32 +: 32] = words[2][i];
        for (int i = 0; i < 16; i++) in3[i*32 +: 32] = words[3][i];
    end

    logic [31:0] out0, out1, out2, out3;
    logic ov0, ov1, ov2, ov3, ir0, ir1, ir2, ir3, se0, se1, se2, se3;
`ifdef MUXN_PIPE_SEL_ECHO_EN
    logic [2:0] so0, so1;
    logic [1:0] so2;
    logic [3:0] so3;
    logic [3:0] so_d [4];
    assign so_d[0] = {1'b0, so0};
    assign so_d[1] = {1'b0, so1};
    assign so_d[2] = {2'b0, so2};
    assign so_d[3] = so3;
`endif

    muxn_pipe #(.N(8), .W(32)) dut0 (
        .clk(clk), .rst(rst), .inputs(in0), .sel(sel_d[0][2:0]), .in_valid(inv_d[0]),
        .in_ready(ir0), .out(out0), .out_valid(ov0), .out_ready(ordy_d[0]), .sel_err(se0)
`ifdef MUXN_PIPE_SEL_ECHO_EN
        , .sel_out(so0)
`endif
    );
    muxn_pipe #(.N(5), .W(32)) dut1 (
        .clk(clk), .rst(rst), .inputs(in1), .sel(sel_d[1][2:0]), .in_valid(inv_d[1]),
        .in_ready(ir1), .out(out1), .out_valid(ov1), .out_ready(ordy_d[1]), .sel_err(se1)
`ifdef MUXN_PIPE_SEL_ECHO_EN
        , .sel_out(so1)
`endif
    );
    muxn_pipe #(.N(4), .W(32)) dut2 (
        .clk(clk), .rst(rst), .inputs(in2), .sel(sel_d[2][1:0]), .in_valid(inv_d[2]),
        .in_ready(ir2), .out(out2), .out_valid(ov2), .out_ready(ordy_d[2]), .sel_err(se2)
`ifdef MUXN_PIPE_SEL_ECHO_EN
        , .sel_out(so2)
`endif
    );
    muxn_pipe #(.N(16), .W(32)) dut3 (
        .clk(clk), .rst(rst), .inputs(in3), .sel(sel_d[3]), .in_valid(inv_d[3]),
        .in_ready(ir3), .out(out3), .out_valid(ov3), .out_ready(ordy_d[3]), .sel_err(se3)
`ifdef MUXN_PIPE_SEL_ECHO_EN
        , .sel_out(so3)
`endif
    );

    assign out_d[0] = out0;  assign out_d[1] = out1;  assign out_d[2] = out2;  assign out_d[3] = out3;
    assign ov_d[0]  = ov0;   assign ov_d[1]  = ov1;   assign ov_d[2]  = ov2;   assign ov_d[3]  = ov3;
    assign ir_d[0]  = ir0;   assign ir_d[1]  = ir1;   assign ir_d[2]  = ir2;   assign ir_d[3]  = ir3;
    assign se_d[0]  = se0;   assign se_d[1]  = se1;   assign se_d[2]  = se2;   assign se_d[3]  = se3;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    item_t       exp_q [4][$];
    logic [32:0] log_q [4][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: items enter a FIFO on input transfer and must leave in order.
    task automatic compare_cycle();
        item_t it;
        item_t head;
        cyc++;
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                exp_q[d].delete();
                chk($sformatf("dut%0d reset out_valid", d), {31'b0, ov_d[d]}, 32'd0);
                chk($sformatf("dut%0d reset out", d), out_d[d], 32'd0);
                chk($sformatf("dut%0d reset in_ready", d), {31'b0, ir_d[d]}, 32'd1);
                chk($sformatf("dut%0d reset sel_err", d), {31'b0, se_d[d]}, 32'd0);
            end else begin
                chk($sformatf("dut%0d in_ready", d), {31'b0, ir_d[d]},
                    {31'b0, (!ov_d[d] || ordy_d[d])});
                if (!ov_d[d]) begin
                    chk($sformatf("dut%0d idle out", d), out_d[d], 32'd0);
                    chk($sformatf("dut%0d idle sel_err", d), {31'b0, se_d[d]}, 32'd0);
`ifdef MUXN_PIPE_SEL_ECHO_EN
                    chk($sformatf("dut%0d idle sel_out", d), {28'b0, so_d[d]}, 32'd0);
`endif
                    if (chk_lat[d] && exp_q[d].size() > 0 &&
                        (cyc - int'(exp_q[d][0].cyc)) >= lat_d[d]) begin
                        chk($sformatf("dut%0d late out_valid", d), {31'b0, ov_d[d]}, 32'd1);
                    end
                end else if (exp_q[d].size() == 0) begin
                    chk($sformatf("dut%0d unexpected out_valid", d), {31'b0, ov_d[d]}, 32'd0);
                end else begin
                    head = exp_q[d][0];
                    chk($sformatf("dut%0d out", d), out_d[d], head.data);
                    chk($sformatf("dut%0d sel_err", d), {31'b0, se_d[d]}, {31'b0, head.err});
`ifdef MUXN_PIPE_SEL_ECHO_EN
                    chk($sformatf("dut%0d sel_out", d), {28'b0, so_d[d]}, {28'b0, head.sel});
`endif
                    if (ordy_d[d]) begin
                        if (chk_lat[d]) begin
                            chk($sformatf("dut%0d latency", d), cyc - head.cyc, lat_d[d]);
                        end
                        void'(exp_q[d].pop_front());
                        log_q[d].push_back({head.err, head.data});
                    end
                end
                if (inv_d[d] && ir_d[d]) begin
                    it.sel  = sel_d[d];
                    it.err  = (int'(sel_d[d]) >= n_d[d]);
                    it.data = it.err ? 32'd0 : words[d][sel_d[d]];
                    it.cyc  = cyc;
                    exp_q[d].push_back(it);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted (bounded).
    task automatic send(input int d, input logic [3:0] s);
        int n;
        n = 0;
        sel_d[d] = s;
        inv_d[d] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ir_d[d] && n < 64);
        if (!ir_d[d]) begin
            chk($sformatf("dut%0d send timeout", d), {31'b0, ir_d[d]}, 32'd1);
        end
        @(posedge clk);
        #1;
        inv_d[d] = 1'b0;
    endtask

    logic        pat [5];
    logic        ovh [12];
    logic [32:0] pin5 [4];
    logic [31:0] pin4 [6];
    bit          done;

    initial begin
        for (int d = 0; d < 4; d++) begin
            sel_d[d] = '0; inv_d[d] = 1'b0; ordy_d[d] = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            words[0][i] = 32'hA0 + i;
            words[1][i] = 32'hB0 + i;
            words[2][i] = 32'hC0 + i;
            words[3][i] = $urandom;
        end
        n_d[0] = 8;  n_d[1] = 5;  n_d[2] = 4;  n_d[3] = 16;
        lat_d[0] = 3; lat_d[1] = 3; lat_d[2] = 2; lat_d[3] = 4;
        chk_lat[0] = 1'b1; chk_lat[1] = 1'b1; chk_lat[2] = 1'b0; chk_lat[3] = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming N=8: sel 0..7 back to back.
        for (int i = 0; i < 8; i++) send(0, 4'(i));
        idle(6);
        chk("stream count", log_q[0].size(), 32'd8);
        for (int i = 0; i < 8 && i < log_q[0].size(); i++) begin
            chk($sformatf("stream pin %0d", i), log_q[0][i][31:0], 32'hA0 + i);
            chk($sformatf("stream pin err %0d", i), {31'b0, log_q[0][i][32]}, 32'd0);
        end

        // Non-power-of-two N=5: sel 4 is a real word, 5..7 land in padding.
        pin5[0] = {1'b0, 32'hB4};
        pin5[1] = {1'b1, 32'h0};
        pin5[2] = {1'b1, 32'h0};
        pin5[3] = {1'b1, 32'h0};
        for (int i = 4; i < 8; i++) send(1, 4'(i));
        idle(6);
        chk("npot count", log_q[1].size(), 32'd4);
        for (int i = 0; i < 4 && i < log_q[1].size(); i++) begin
            chk($sformatf("npot pin %0d", i), log_q[1][i][31:0], pin5[i][31:0]);
            chk($sformatf("npot pin err %0d", i), {31'b0, log_q[1][i][32]}, {31'b0, pin5[i][32]});
        end

        // Backpressure N=4: fill, stall 4 cycles, release.
        pin4[0] = 32'hC0; pin4[1] = 32'hC1; pin4[2] = 32'hC2;
        pin4[3] = 32'hC3; pin4[4] = 32'hC0; pin4[5] = 32'hC1;
        ordy_d[2] = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(2, 4'(i % 4));
            end
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall in_ready", {31'b0, ir_d[2]}, 32'd0);
                    chk("stall out_valid", {31'b0, ov_d[2]}, 32'd1);
                end
                @(posedge clk);
                #1 ordy_d[2] = 1'b1;
            end
        join
        idle(6);
        chk("bp count", log_q[2].size(), 32'd6);
        for (int i = 0; i < 6 && i < log_q[2].size(); i++) begin
            chk($sformatf("bp pin %0d", i), log_q[2][i][31:0], pin4[i]);
        end

        // Bubbles on N=8: out_valid pattern is in_valid delayed by 3.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (j < 5) inv_d[0] = pat[j];
            else       inv_d[0] = 1'b0;
            sel_d[0] = 4'(j % 8);
            @(negedge clk);
            ovh[j] = ov_d[0];
            @(posedge clk);
            #1;
        end
        inv_d[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bubble %0d", i), {31'b0, ovh[i+3]}, {31'b0, pat[i]});
        end

        // Reset with three items in flight on N=8.
        send(0, 4'd1);
        send(0, 4'd2);
        send(0, 4'd3);
        chk("pre-reset out_valid", {31'b0, ov_d[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid-reset out_valid", {31'b0, ov_d[0]}, 32'd0);
        chk("mid-reset out", out_d[0], 32'd0);
        chk("mid-reset in_ready", {31'b0, ir_d[0]}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(8);

        // N=16: random selects/words with random out_ready.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    for (int k = 0; k < 16; k++) words[3][k] = $urandom;
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(3, 4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ordy_d[3] = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                ordy_d[3] = 1'b1;
            end
        join
        idle(20);
        chk("random count", log_q[3].size(), 32'd40);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("dut%0d drained", d), exp_q[d].size(), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
